// File: rtl/adc_scan_ctrl_if.sv
// rtl/adc_scan_ctrl_if.sv - control, sample and read-port bundle of the ADC scan sequencer
interface adc_scan_ctrl_if;
    logic        ctrl_start;
    logic        ctrl_continuous;
    logic [7:0]  ch_mask;
    logic        busy;
    logic        done;
    logic        sample_valid;
    logic [2:0]  sample_ch;
    logic [11:0] sample_data;
    logic [2:0]  rd_addr;
    logic [11:0] rd_data;

    modport master (
        output ctrl_start, ctrl_continuous, ch_mask, rd_addr,
        input  busy, done, sample_valid, sample_ch, sample_data, rd_data
    );

    modport slave (
        input  ctrl_start, ctrl_continuous, ch_mask, rd_addr,
        output busy, done, sample_valid, sample_ch, sample_data, rd_data
    );
endinterface

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - LTC2308 channel scan sequencer with per-channel result file
module adc_scan_ctrl #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80
) (
    input  logic           clk,
    input  logic           reset_n,
    adc_scan_ctrl_if.slave bus,
    output logic           adc_cs_n,
    output logic           adc_sclk,
    output logic           adc_din,
    input  logic           adc_dout
);
    typedef enum logic [1:0] {IDLE, CONV, SHIFT, LOAD} state_t;

    localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [4:0]  HALF_LAST = 5'd23;

    state_t      state;
    logic [15:0] cnt;
    logic [4:0]  hcnt;
    logic [7:0]  dcnt;
    logic [7:0]  mask_q;
    logic [2:0]  cur_cfg;
    logic [2:0]  prev_cfg;
    logic        first;
    logic [11:0] shreg;
    logic [11:0] results [8];

    logic        sample_now;
    logic        shift_end;
    logic [11:0] sh_next;
    logic [4:0]  nh;
    logic [7:0]  nd;
    logic [3:0]  nb;
    logic [5:0]  cur_word;
    logic        nbit;
    logic [2:0]  lo_ch;
    logic [2:0]  hi_ch;
    logic [2:0]  nxt_ch;
    logic        stop;

    // {S/D, O/S, S1, S0, UNI, SLP}: single-ended, unipolar, no sleep
    function automatic logic [5:0] cfg_word(input logic [2:0] ch);
        return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
    endfunction

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [2:0] highest(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (m[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [2:0] next_en(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] r;
        logic [2:0] c;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i < 8; i++) begin
            c = cur + 3'(i);
            if (!found && m[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        sample_now = (state == SHIFT) && hcnt[0] && (dcnt == '0);
        sh_next    = sample_now ? {shreg[10:0], adc_dout} : shreg;
        shift_end  = (state == SHIFT) && (hcnt == HALF_LAST) && (dcnt == DIV_LAST);
        if (dcnt == DIV_LAST) begin
            nh = hcnt + 5'd1;
            nd = '0;
        end else begin
            nh = hcnt;
            nd = dcnt + 8'd1;
        end
        // config bit index = number of falling SCLK edges seen by the next cycle
        nb       = nh[4:1];
        cur_word = cfg_word(cur_cfg);
        nbit     = (nb < 4'd6) ? cur_word[3'd5 - nb[2:0]] : 1'b0;
        lo_ch    = lowest(bus.ch_mask);
        hi_ch    = highest(mask_q);
        nxt_ch   = next_en(mask_q, cur_cfg);
        stop     = !first && (prev_cfg == hi_ch) && !bus.ctrl_continuous;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            cnt              <= '0;
            hcnt             <= '0;
            dcnt             <= '0;
            mask_q           <= '0;
            cur_cfg          <= '0;
            prev_cfg         <= '0;
            first            <= 1'b0;
            shreg            <= '0;
            for (int i = 0; i < 8; i++) results[i] <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.sample_valid <= 1'b0;
            bus.sample_ch    <= '0;
            bus.sample_data  <= '0;
            bus.rd_data      <= '0;
            adc_cs_n         <= 1'b0;
            adc_sclk         <= 1'b0;
            adc_din          <= 1'b0;
        end else begin
            bus.sample_valid <= 1'b0;
            bus.done         <= 1'b0;
            bus.rd_data      <= results[bus.rd_addr];
            case (state)
                IDLE: begin
                    if (bus.ctrl_start && (bus.ch_mask != '0)) begin
                        mask_q   <= bus.ch_mask;
                        cur_cfg  <= lo_ch;
                        first    <= 1'b1;
                        bus.busy <= 1'b1;
                        state    <= CONV;
                        cnt      <= '0;
                        adc_cs_n <= 1'b1;
                        adc_sclk <= 1'b0;
                        adc_din  <= 1'b1;
                    end
                end
                CONV: begin
                    adc_cs_n <= (cnt == '0);
                    if (cnt == CONV_LAST) begin
                        state <= SHIFT;
                        hcnt  <= '0;
                        dcnt  <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    shreg    <= sh_next;
                    hcnt     <= nh;
                    dcnt     <= nd;
                    adc_sclk <= nh[0];
                    adc_din  <= nbit;
                    // sample/done are presented during the LOAD cycle itself
                    if (shift_end) begin
                        state            <= LOAD;
                        adc_sclk         <= 1'b0;
                        adc_din          <= 1'b0;
                        bus.sample_valid <= !first;
                        bus.done         <= stop;
                        if (!first) begin
                            bus.sample_ch   <= prev_cfg;
                            bus.sample_data <= sh_next;
                        end
                    end
                end
                LOAD: begin
                    if (!first) results[prev_cfg] <= shreg;
                    first    <= 1'b0;
                    prev_cfg <= cur_cfg;
                    cur_cfg  <= nxt_ch;
                    if (bus.done) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        state    <= CONV;
                        cnt      <= '0;
                        adc_cs_n <= 1'b1;
                        adc_din  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Sequencer for the on-board LTC2308 8-channel 12-bit SPI ADC. It scans a programmable set of single-ended channels, in single-pass or continuous mode, and stores the latest result per channel in an internal register file. Its pins drive the `adc_cs_n`, `adc_sclk`, `adc_din` and `adc_dout` top-level nets. A memory-mapped slave wrapper uses the control and read ports.

## Interface
- `CLK_DIV`, 2: clk cycles per `adc_sclk` half-period (≥1); 12.5 MHz SCLK at 50 MHz.
- `CONV_CYCLES`, 80: clk cycles in CONV state (≥3); 1.6 µs at 50 MHz.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ctrl_start`  in  1  single-cycle pulse, starts a scan.
- `ctrl_continuous`  in  1  1 = repeat passes. Sampled live at each pass end.
- `ch_mask`  in  8  enabled channels. Latched on an accepted start.
- `busy`  out  1  scan in progress.
- `done`  out  1  1-cycle pulse when the scan ends.
- `sample_valid`  out  1  1-cycle pulse for each new result.
- `sample_ch`  out  3  channel of `sample_data`.
- `sample_data`  out  12  result, held until the next `sample_valid`.
- `rd_addr`  in  3  register-file read address.
- `rd_data`  out  12  registered read data.
- `adc_cs_n`  out  1  CONVST; a high pulse starts a conversion.
- `adc_sclk`  out  1  SPI clock; idles low.
- `adc_din`  out  1  config bits to the ADC.
- `adc_dout`  in  1  result bits from the ADC.

## Operation
- Reset state:
  - All outputs are 0.
  - FSM is in IDLE.
  - All 8 result registers are 0.
- FSM states: IDLE → CONV → SHIFT → LOAD → CONV … → IDLE.
- IDLE:
  - An accepted start is `ctrl_start`=1 with `ch_mask`≠0.
  - On an accepted start: latch the mask, set `busy`, set `cur_cfg` = lowest enabled channel, set the `first` flag, go to CONV.
  - `ctrl_start` is ignored when `ch_mask`=0 or when busy.
- CONV (CONV_CYCLES cycles):
  - `adc_cs_n`=1 for the first 2 cycles, 0 for the rest.
  - `adc_sclk`=0 throughout.
  - `adc_din` = MSB of the config word for `cur_cfg`.
- Config word (6 bits, MSB first): {S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=1, SLP=0}.
  - ch0 = 100010.
  - ch5 = 111010.
- SHIFT (24·CLK_DIV cycles, 12 SCLK periods):
  - Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
  - `adc_dout` is sampled on the clk cycle where `adc_sclk` goes 0→1, into a shift register, MSB first.
  - `adc_din` advances to the next config bit on each 1→0 edge.
  - After the 6 config bits, `adc_din`=0.
  - `adc_sclk` is low on exit.
- LOAD (1 cycle). Pipeline rule: the frame's result belongs to the channel configured in the *previous* frame (`prev_cfg`).
  - If `first` is set: discard the result and clear `first`.
  - Otherwise:
    - write the shift register to `results[prev_cfg]`;
    - set `sample_ch`=`prev_cfg` and `sample_data`=the result;
    - pulse `sample_valid`.
  - Then set `prev_cfg`=`cur_cfg` and `cur_cfg` = next enabled channel above `cur_cfg`, wrapping 7→0.
  - A pass ends when the written channel is the highest enabled channel.
  - At pass end, if `ctrl_continuous`=1: go to CONV with no discard frame.
  - At pass end, if `ctrl_continuous`=0: pulse `done`, clear `busy`, go to IDLE. The conversion already started is abandoned.
  - Not at pass end: go to CONV.
- Read port:
  - `rd_data` ← `results[rd_addr]` every cycle.
  - A read and a LOAD write to the same entry in one cycle return the old value. The new value appears one cycle later.

## Timing
- One frame = F = CONV_CYCLES + 24·CLK_DIV + 1 clk cycles (129 at defaults, ≈388 kS/s).
- With a start accepted in cycle t:
  - CONV starts in cycle t+1.
  - `adc_cs_n` is high in cycles t+1 and t+2.
  - Frame k's LOAD falls in cycle t+k·F.
- A single pass over N channels takes N+1 frames. `done` and the last `sample_valid` fall in the same cycle, t+(N+1)·F.
- `busy`:
  - goes high in cycle t+1;
  - goes low in the cycle after `done`.
- `rd_data` latency is 1 cycle.
- Asynchronous reset mid-frame:
  - All outputs and results go to 0 immediately.
  - The ADC's pending conversion is harmless, because the next scan discards its first result.

## Test plan
- Reset check. Reset asserted mid-SHIFT → all outputs 0 with no clock edge; `rd_data` reads 0 for all addresses after release.
- Single scan, mask 0x01, ADC model returns 0xABC, defaults:
  - `adc_din` is 100010 in both frames.
  - One `sample_valid` with ch0 / 0xABC at t+258.
  - `done` at t+258.
  - `busy` is low from t+259.
- Mask 0xA4, model returns 0x100+ch:
  - Config sequence is ch2, ch5, ch7, ch2; ch5 config is 111010.
  - Samples are (2, 0x102), (5, 0x105), (7, 0x107).
  - `done` only with the ch7 sample.
- Continuous mode, mask 0xFF:
  - The ch0 sample follows the ch7 sample by exactly F cycles (no discard).
  - Drop `ctrl_continuous` mid-pass → stops after the ch7 sample with `done`.
- Ignored starts: `ctrl_start` with mask 0 → `busy` stays 0. `ctrl_start` while busy → no effect on sequence or mask.
- Read collision: `rd_addr`=ch equal to the LOAD channel in the LOAD cycle → next cycle shows the old value, the following cycle shows the new one.
